// File: rtl/issue_sched_pkg.sv
// Shared types for the issue scheduler: execute-unit codes, register ids and the queue entry.
package issue_sched_pkg;
  localparam int UNIT_NUM = 6;

  typedef enum logic [2:0] {
    UNIT_ALU  = 3'd0,
    UNIT_DIV  = 3'd1,
    UNIT_FPU  = 3'd2,
    UNIT_FDIV = 3'd3,
    UNIT_CSR  = 3'd4,
    UNIT_MEM  = 3'd5
  } ExeUnit_t;

  typedef logic [5:0] RegFile_t;

  // ROB tag is parameterized at the top, so it lives in a side array next to this struct.
  typedef struct packed {
    logic       valid;
    logic [2:0] unit;
    RegFile_t   rd;
    RegFile_t   rs1;
    RegFile_t   rs2;
    logic       rs1_rdy;
    logic       rs2_rdy;
  } IssueEntry_t;

  // Index of the lowest set bit; 0 when none is set.
  function automatic logic [3:0] find_first_set(input logic [15:0] vec);
    find_first_set = '0;
    for (int i = 15; i >= 0; i--)
      if (vec[i]) find_first_set = i[3:0];
  endfunction
endpackage

// File: rtl/issue_sched_if.sv
// Dispatch / CDB / issue bundle. master = surrounding pipeline, slave = the scheduler.
interface issue_sched_if #(parameter int TAG = 6) ();
  import issue_sched_pkg::*;

  logic                flush;
  logic                disp_valid;
  logic                disp_ready;
  logic [2:0]          disp_unit;
  RegFile_t            disp_rd;
  RegFile_t            disp_rs1;
  RegFile_t            disp_rs2;
  logic                disp_rs1_rdy;
  logic                disp_rs2_rdy;
  logic [TAG-1:0]      disp_tag;
  logic                cdb_valid;
  RegFile_t            cdb_rd;
  logic [UNIT_NUM-1:0] exe_busy;
  logic                is_valid;
  logic                is_ready;
  logic [2:0]          is_unit;
  RegFile_t            is_rd;
  RegFile_t            is_rs1;
  RegFile_t            is_rs2;
  logic [TAG-1:0]      is_tag;

  modport master (
    output flush, disp_valid, disp_unit, disp_rd, disp_rs1, disp_rs2,
           disp_rs1_rdy, disp_rs2_rdy, disp_tag, cdb_valid, cdb_rd, exe_busy, is_ready,
    input  disp_ready, is_valid, is_unit, is_rd, is_rs1, is_rs2, is_tag
  );

  modport slave (
    input  flush, disp_valid, disp_unit, disp_rd, disp_rs1, disp_rs2,
           disp_rs1_rdy, disp_rs2_rdy, disp_tag, cdb_valid, cdb_rd, exe_busy, is_ready,
    output disp_ready, is_valid, is_unit, is_rd, is_rs1, is_rs2, is_tag
  );
endinterface

// File: rtl/issue_sched_age_matrix.sv
// Dispatch-order age matrix: older_q[i][j] set means entry j was dispatched before entry i.
module issue_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] vld_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] gnt_o
);
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    for (int j = 0; j < DEPTH; j++)
      if (free_i[j])
        for (int i = 0; i < DEPTH; i++) older_d[i][j] = 1'b0;
    // A new entry is younger than everything still resident.
    for (int i = 0; i < DEPTH; i++)
      if (alloc_i[i]) older_d[i] = vld_i & ~free_i;
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < DEPTH; i++)
      gnt_o[i] = req_i[i] && !(|(older_q[i] & req_i));
  end

  always_ff @(posedge clk) begin
    if (reset || clr_i) older_q <= '0;
    else                older_q <= older_d;
  end
endmodule

// File: rtl/issue_sched.sv
// Out-of-order issue scheduler: issue queue, CDB wakeup, oldest-ready select, registered issue port.
// Define ISSUE_WAKEUP_BYPASS_EN to let a CDB hit make an entry eligible in the same cycle.
module issue_sched #(
  parameter int DEPTH = 8,
  parameter int TAG   = 6
) (
  input logic          clk,
  input logic          reset,
  issue_sched_if.slave io
);
  import issue_sched_pkg::*;

  IssueEntry_t [DEPTH-1:0]      ent_q, ent_d;
  logic [DEPTH-1:0][TAG-1:0]    tag_q, tag_d;
  logic [DEPTH-1:0]             vld, hit1, hit2, rdy1, rdy2, req, gnt, alloc, free;
  logic [7:0]                   busy_ext;
  logic [3:0]                   ff_idx;
  logic                         disp_fire, ld;
  IssueEntry_t                  new_e;

  logic                         is_valid_q, is_valid_d;
  logic [2:0]                   is_unit_q, is_unit_d;
  RegFile_t                     is_rd_q, is_rd_d, is_rs1_q, is_rs1_d, is_rs2_q, is_rs2_d;
  logic [TAG-1:0]               is_tag_q, is_tag_d;

  assign io.disp_ready = !reset && !(&vld);
  assign disp_fire     = io.disp_valid && io.disp_ready && !io.flush;
  assign ld            = !is_valid_q || io.is_ready;
  assign free          = ld ? gnt : '0;
  assign ff_idx        = find_first_set(16'(~vld));
  assign alloc         = disp_fire ? (DEPTH'(1) << ff_idx) : '0;

  // Illegal unit codes read as permanently busy, so they can never be selected.
  always_comb begin
    busy_ext = {2'b11, io.exe_busy};
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]  = ent_q[i].valid;
      hit1[i] = io.cdb_valid && (ent_q[i].rs1 == io.cdb_rd);
      hit2[i] = io.cdb_valid && (ent_q[i].rs2 == io.cdb_rd);
`ifdef ISSUE_WAKEUP_BYPASS_EN
      rdy1[i] = ent_q[i].rs1_rdy | hit1[i];
      rdy2[i] = ent_q[i].rs2_rdy | hit2[i];
`else
      rdy1[i] = ent_q[i].rs1_rdy;
      rdy2[i] = ent_q[i].rs2_rdy;
`endif
      req[i]  = ent_q[i].valid && rdy1[i] && rdy2[i] && !busy_ext[ent_q[i].unit];
    end
  end

  issue_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (io.flush),
    .alloc_i (alloc),
    .free_i  (free),
    .vld_i   (vld),
    .req_i   (req),
    .gnt_o   (gnt)
  );

  always_comb begin
    new_e.valid   = 1'b1;
    new_e.unit    = io.disp_unit;
    new_e.rd      = io.disp_rd;
    new_e.rs1     = io.disp_rs1;
    new_e.rs2     = io.disp_rs2;
    new_e.rs1_rdy = io.disp_rs1_rdy || (io.disp_rs1 == '0) ||
                    (io.cdb_valid && (io.disp_rs1 == io.cdb_rd));
    new_e.rs2_rdy = io.disp_rs2_rdy || (io.disp_rs2 == '0) ||
                    (io.cdb_valid && (io.disp_rs2 == io.cdb_rd));
  end

  always_comb begin
    ent_d = ent_q;
    tag_d = tag_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].rs1_rdy = ent_q[i].rs1_rdy | hit1[i];
      ent_d[i].rs2_rdy = ent_q[i].rs2_rdy | hit2[i];
      if (free[i]) ent_d[i].valid = 1'b0;
      if (alloc[i]) begin
        ent_d[i] = new_e;
        tag_d[i] = io.disp_tag;
      end
      if (io.flush) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    is_valid_d = is_valid_q;
    is_unit_d  = is_unit_q;
    is_rd_d    = is_rd_q;
    is_rs1_d   = is_rs1_q;
    is_rs2_d   = is_rs2_q;
    is_tag_d   = is_tag_q;
    if (io.flush) begin
      is_valid_d = 1'b0;
    end else if (ld) begin
      is_valid_d = |gnt;
      for (int i = 0; i < DEPTH; i++)
        if (gnt[i]) begin
          is_unit_d = ent_q[i].unit;
          is_rd_d   = ent_q[i].rd;
          is_rs1_d  = ent_q[i].rs1;
          is_rs2_d  = ent_q[i].rs2;
          is_tag_d  = tag_q[i];
        end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q      <= '0;
      tag_q      <= '0;
      is_valid_q <= 1'b0;
      is_unit_q  <= '0;
      is_rd_q    <= '0;
      is_rs1_q   <= '0;
      is_rs2_q   <= '0;
      is_tag_q   <= '0;
    end else begin
      ent_q      <= ent_d;
      tag_q      <= tag_d;
      is_valid_q <= is_valid_d;
      is_unit_q  <= is_unit_d;
      is_rd_q    <= is_rd_d;
      is_rs1_q   <= is_rs1_d;
      is_rs2_q   <= is_rs2_d;
      is_tag_q   <= is_tag_d;
    end
  end

  assign io.is_valid = is_valid_q;
  assign io.is_unit  = is_unit_q;
  assign io.is_rd    = is_rd_q;
  assign io.is_rs1   = is_rs1_q;
  assign io.is_rs2   = is_rs2_q;
  assign io.is_tag   = is_tag_q;

  a_legal_unit: assert property (@(posedge clk) disable iff (reset)
    (io.disp_valid && io.disp_ready) |-> (io.disp_unit < 3'(UNIT_NUM)));
endmodule
